// File: rtl/riscv_pkg.sv
// Shared pipeline types: hazard sequencer states and the bundled stall/flush control word.
package riscv_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_DRAIN    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_stall;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_IDLE = '0;

    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_stall:     1'b1,
        if_id_flush:  1'b1,
        id_ex_flush:  1'b1,
        ex_mem_flush: 1'b1,
        mem_wb_flush: 1'b1,
        default:      1'b0
    };

    // A register being flushed must not also be held; mem_wb_stall is reserved.
    function automatic hz_ctrl_t hz_flush_wins(input hz_ctrl_t c);
        hz_ctrl_t r;
        r              = c;
        r.if_id_stall  = c.if_id_stall  & ~c.if_id_flush;
        r.id_ex_stall  = c.id_ex_stall  & ~c.id_ex_flush;
        r.ex_mem_stall = c.ex_mem_stall & ~c.ex_mem_flush;
        r.mem_wb_stall = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/hz_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a source read in ID.
module hz_load_use_detect
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic [1:0][REG_ADDR_W-1:0] src;
    logic [1:0]                 src_used;
    logic [1:0]                 src_hit;

    assign src[0]      = id_rs1;
    assign src[1]      = id_rs2;
    assign src_used[0] = id_uses_rs1;
    assign src_used[1] = id_uses_rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_used[gi] && (src[gi] == ex_rd);
    end

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, redirect, dmem wait, trap/timeout drain).
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int MEM_TIMEOUT  = 256,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    input  logic                  trap_req,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_stall,
    output logic                  mem_wb_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
`endif
    output logic                  mem_timeout_err
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    hz_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic     load_use;
    logic     mem_wait;
    logic     trap_evt, timeout_evt, redirect_evt, lu_evt;
    hz_ctrl_t ctrl_raw, ctrl_out;
    logic     timeout_err;

    hz_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_wait = mem_req && !dmem_ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        ctrl_raw     = HZ_CTRL_IDLE;
        trap_evt     = 1'b0;
        timeout_evt  = 1'b0;
        redirect_evt = 1'b0;
        lu_evt       = 1'b0;

        if (state_q == HZ_DRAIN) begin
            // Upstream stays flushed while the PC fetches from the trap vector.
            ctrl_raw.if_id_flush  = 1'b1;
            ctrl_raw.id_ex_flush  = 1'b1;
            ctrl_raw.ex_mem_flush = 1'b1;
            if (drain_cnt_q == '0) begin
                state_d = HZ_RUN;
            end else begin
                drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            end
        end else if (trap_req ||
                     (state_q == HZ_MEM_WAIT && mem_wait &&
                      wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1))) begin
            trap_evt              = trap_req;
            timeout_evt           = !trap_req;
            ctrl_raw.if_id_flush  = 1'b1;
            ctrl_raw.id_ex_flush  = 1'b1;
            ctrl_raw.ex_mem_flush = 1'b1;
            state_d               = HZ_DRAIN;
            drain_cnt_d           = DRAIN_W'(DRAIN_CYCLES - 1);
            wait_cnt_d            = '0;
        end else if (mem_wait) begin
            ctrl_raw.pc_stall     = 1'b1;
            ctrl_raw.if_id_stall  = 1'b1;
            ctrl_raw.id_ex_stall  = 1'b1;
            ctrl_raw.ex_mem_stall = 1'b1;
            ctrl_raw.mem_wb_flush = 1'b1;
            state_d               = HZ_MEM_WAIT;
            wait_cnt_d            = wait_cnt_q + WAIT_W'(1);
        end else begin
            if (state_q == HZ_MEM_WAIT) begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
            // A redirect makes the ID instruction wrong-path, so its load-use is moot.
            if (ex_redirect) begin
                redirect_evt         = 1'b1;
                ctrl_raw.if_id_flush = 1'b1;
                ctrl_raw.id_ex_flush = 1'b1;
            end else if (load_use) begin
                lu_evt               = 1'b1;
                ctrl_raw.pc_stall    = 1'b1;
                ctrl_raw.if_id_stall = 1'b1;
                ctrl_raw.id_ex_flush = 1'b1;
            end
        end

        if (rst) begin
            ctrl_out    = HZ_CTRL_RESET;
            timeout_err = 1'b0;
        end else begin
            ctrl_out    = hz_flush_wins(ctrl_raw);
            timeout_err = timeout_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign pc_stall        = ctrl_out.pc_stall;
    assign if_id_stall     = ctrl_out.if_id_stall;
    assign if_id_flush     = ctrl_out.if_id_flush;
    assign id_ex_stall     = ctrl_out.id_ex_stall;
    assign id_ex_flush     = ctrl_out.id_ex_flush;
    assign ex_mem_stall    = ctrl_out.ex_mem_stall;
    assign ex_mem_flush    = ctrl_out.ex_mem_flush;
    assign mem_wb_stall    = ctrl_out.mem_wb_stall;
    assign mem_wb_flush    = ctrl_out.mem_wb_flush;
    assign mem_timeout_err = timeout_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Flush events count once per hazard, never per DRAIN cycle.
    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, ctrl_out.pc_stall};
        perf_flush_d = perf_flush_q +
                       {31'd0, (redirect_evt | lu_evt | trap_evt | timeout_evt)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Without the perf counters the event strobes only steer the control word.
    logic unused_evt;
    assign unused_evt = redirect_evt ^ lu_evt ^ trap_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks feeding an expected-value scoreboard.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       mreq;
        logic       rdy;
        logic       trap;
        logic       redir;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
    } stim_t;

    // {pc, if_id_s, if_id_f, id_ex_s, id_ex_f, ex_mem_s, ex_mem_f, mem_wb_s, mem_wb_f, err}
    localparam logic [9:0] E_IDLE  = 10'b0000000000;
    localparam logic [9:0] E_RST   = 10'b1010101010;
    localparam logic [9:0] E_LU    = 10'b1100100000;
    localparam logic [9:0] E_REDIR = 10'b0010100000;
    localparam logic [9:0] E_MWAIT = 10'b1101010010;
    localparam logic [9:0] E_TRAP  = 10'b0010101000;
    localparam logic [9:0] E_TMO   = 10'b0010101001;
    localparam logic [9:0] E_DRAIN = 10'b0010101000;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic       mem_req, dmem_ready, trap_req;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    pipe_hazard_ctrl #(
        .REG_ADDR_W   (5),
        .MEM_TIMEOUT  (4),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_redirect     (ex_redirect),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .trap_req        (trap_req),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_stall    (mem_wb_stall),
        .mem_wb_flush    (mem_wb_flush),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
`endif
        .mem_timeout_err (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic r, input logic mq, input logic rd_y,
                                 input logic tp, input logic rdr, input logic m_r,
                                 input logic [4:0] d, input logic [4:0] s1, input logic us1,
                                 input logic [4:0] s2, input logic us2);
        stim_t s;
        s = '{rst: r, mreq: mq, rdy: rd_y, trap: tp, redir: rdr, mr: m_r,
              rd: d, rs1: s1, u1: us1, rs2: s2, u2: us2};
        return s;
    endfunction

    function automatic logic [9:0] observed();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_timeout_err};
    endfunction

    // Applies one cycle of stimulus just after the active edge.
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst         = s.rst;
        mem_req     = s.mreq;
        dmem_ready  = s.rdy;
        trap_req    = s.trap;
        ex_redirect = s.redir;
        ex_mem_read = s.mr;
        ex_rd       = s.rd;
        id_rs1      = s.rs1;
        id_uses_rs1 = s.u1;
        id_rs2      = s.rs2;
        id_uses_rs2 = s.u2;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
        s.push_back(st(1, 1, 0, 1, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0)); e.push_back(E_RST);
        s.push_back(st(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_RST);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset step %0d: got=%b want=%b", i, got, want);
            end else $display("reset step %0d ok out=%b", i, got);
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
        s.push_back(st(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0)); e.push_back(E_LU);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        s.push_back(st(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1)); e.push_back(E_IDLE);
        s.push_back(st(0, 0, 0, 0, 0, 1, 5'd7, 5'd2, 1, 5'd7, 1)); e.push_back(E_LU);
        s.push_back(st(0, 0, 0, 0, 0, 1, 5'd7, 5'd2, 1, 5'd7, 0)); e.push_back(E_IDLE);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_use step %0d: got=%b want=%b", i, got, want);
            end else $display("load_use step %0d ok out=%b", i, got);
        end
    endtask

    task automatic test_redirect();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
`ifdef HAZARD_PERF_CNT_EN
        logic [31:0] f0;
        f0 = perf_flush_cnt;
`endif
        s.push_back(st(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0)); e.push_back(E_REDIR);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL redirect step %0d: got=%b want=%b", i, got, want);
            end else $display("redirect step %0d ok out=%b", i, got);
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (perf_flush_cnt - f0 !== 32'd1) begin
            bad++;
            $display("FAIL perf_flush_redirect: got=%0d want=1", perf_flush_cnt - f0);
        end else $display("perf_flush_redirect ok delta=1");
`endif
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
`ifdef HAZARD_PERF_CNT_EN
        logic [31:0] p0;
        p0 = perf_stall_cnt;
`endif
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL mem_wait step %0d: got=%b want=%b", i, got, want);
            end else $display("mem_wait step %0d ok out=%b", i, got);
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (perf_stall_cnt - p0 !== 32'd3) begin
            bad++;
            $display("FAIL perf_stall_memwait: got=%0d want=3", perf_stall_cnt - p0);
        end else $display("perf_stall_memwait ok delta=3");
`endif
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
        // Redirect and load-use held off by the wait, then redirect honoured on release.
        s.push_back(st(0, 1, 0, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 1, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0)); e.push_back(E_REDIR);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 1, 0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1)); e.push_back(E_LU);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back step %0d: got=%b want=%b", i, got, want);
            end else $display("back_to_back step %0d ok out=%b", i, got);
        end
    endtask

    task automatic test_timeout();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_TMO);
        s.push_back(st(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_DRAIN);
        s.push_back(st(0, 1, 0, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0)); e.push_back(E_DRAIN);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL timeout step %0d: got=%b want=%b", i, got, want);
            end else $display("timeout step %0d ok out=%b", i, got);
        end
    endtask

    task automatic test_trap_reset();
        stim_t s[$];
        logic [9:0] e[$];
        logic [9:0] want, got;
        s.push_back(st(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_TRAP);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_DRAIN);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_DRAIN);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_TRAP);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_DRAIN);
        s.push_back(st(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_RST);
        s.push_back(st(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_RST);
        s.push_back(st(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        s.push_back(st(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_MWAIT);
        s.push_back(st(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0)); e.push_back(E_IDLE);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL trap_reset step %0d: got=%b want=%b", i, got, want);
            end else $display("trap_reset step %0d ok out=%b", i, got);
        end
    endtask

    initial begin
        rst         = 1'b1;
        id_rs1      = '0;
        id_rs2      = '0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_rd       = '0;
        ex_mem_read = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        dmem_ready  = 1'b0;
        trap_req    = 1'b0;

        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_trap_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
